// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// State encoding, legal opcodes and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        TRAP
    } state_t;

    localparam int OP_LI  = 0;
    localparam int OP_ADD = 1;
    localparam int OP_JMP = 3;

    localparam int ALU_CON_LI  = 0;
    localparam int ALU_CON_ADD = 1;
    localparam int ALU_CON_JMP = 3;

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Opcode decoder: maps the latched opcode to ALU controls and jump/illegal flags.
// Any code outside li/add/jump is reported as illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 2,
    parameter int ALU_CON_W = 2
) (
    input  logic [OPCODE_W-1:0]  i_opcode,
    output logic [ALU_CON_W-1:0] o_alu_con,
    output logic                 o_imm_sel,
    output logic                 o_alu_src,
    output logic                 o_is_jump,
    output logic                 o_is_illegal
);

    always_comb begin
        o_alu_con    = '0;
        o_imm_sel    = 1'b0;
        o_alu_src    = 1'b0;
        o_is_jump    = 1'b0;
        o_is_illegal = 1'b0;
        if (i_opcode == OPCODE_W'(OP_LI)) begin
            o_alu_con = ALU_CON_W'(ALU_CON_LI);
            o_imm_sel = 1'b1;
            o_alu_src = 1'b1;
        end else if (i_opcode == OPCODE_W'(OP_ADD)) begin
            o_alu_con = ALU_CON_W'(ALU_CON_ADD);
        end else if (i_opcode == OPCODE_W'(OP_JMP)) begin
            o_alu_con = ALU_CON_W'(ALU_CON_JMP);
            o_is_jump = 1'b1;
        end else begin
            o_is_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/WB sequencing with imem handshake,
// stall, illegal-opcode trap and a retired-instruction counter.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 2,
    parameter int CNT_W     = 16,
    parameter int ALU_CON_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_fetch_ack,
    input  logic [OPCODE_W-1:0]  i_opcode,
    input  logic                 i_stall,
    input  logic                 i_trap_clr,
    output logic                 o_fetch_req,
    output logic                 o_reg_write,
    output logic [ALU_CON_W-1:0] o_alu_con,
    output logic                 o_imm_sel,
    output logic                 o_alu_src,
    output logic                 o_pc_inc,
    output logic                 o_pc_load,
    output logic                 o_busy,
    output logic                 o_illegal,
    output logic [CNT_W-1:0]     o_retired
);

    state_t                r_state;
    state_t                w_next;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [CNT_W-1:0]      r_retired;
    logic                  w_retire;
    logic [ALU_CON_W-1:0]  w_alu_con;
    logic                  w_imm_sel;
    logic                  w_alu_src;
    logic                  w_is_jump;
    logic                  w_is_illegal;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_CON_W(ALU_CON_W)
    ) u_decode (
        .i_opcode    (r_opcode),
        .o_alu_con   (w_alu_con),
        .o_imm_sel   (w_imm_sel),
        .o_alu_src   (w_alu_src),
        .o_is_jump   (w_is_jump),
        .o_is_illegal(w_is_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_opcode  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH && i_fetch_ack)
                r_opcode <= i_opcode;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Pulses (reg_write/pc_inc/pc_load) are gated by stall so each fires once,
    // in the first unstalled cycle of its state.
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        o_fetch_req = 1'b0;
        o_reg_write = 1'b0;
        o_alu_con   = '0;
        o_imm_sel   = 1'b0;
        o_alu_src   = 1'b0;
        o_pc_inc    = 1'b0;
        o_pc_load   = 1'b0;
        o_busy      = 1'b0;
        o_illegal   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start)
                    w_next = FETCH;
            end
            FETCH: begin
                o_fetch_req = 1'b1;
                o_busy      = 1'b1;
                if (i_fetch_ack)
                    w_next = DECODE;
            end
            DECODE: begin
                o_busy = 1'b1;
                if (!i_stall)
                    w_next = w_is_illegal ? TRAP : EXEC;
            end
            EXEC: begin
                o_busy    = 1'b1;
                o_alu_con = w_alu_con;
                o_imm_sel = w_imm_sel;
                o_alu_src = w_alu_src;
                if (w_is_jump) begin
                    o_pc_load = !i_stall;
                    if (!i_stall) begin
                        w_next   = FETCH;
                        w_retire = 1'b1;
                    end
                end else if (!i_stall) begin
                    w_next = WB;
                end
            end
            WB: begin
                o_busy      = 1'b1;
                o_alu_con   = w_alu_con;
                o_imm_sel   = w_imm_sel;
                o_alu_src   = w_alu_src;
                o_reg_write = !i_stall;
                o_pc_inc    = !i_stall;
                if (!i_stall) begin
                    w_next   = FETCH;
                    w_retire = 1'b1;
                end
            end
            TRAP: begin
                o_illegal = 1'b1;
                if (i_trap_clr)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: per-cycle vector table plus async-reset sequence; a second
// instance (OPCODE_W=4, CNT_W=2) shadows the first to cover wide opcodes and wrap.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, fetch_ack, stall, trap_clr;
    logic [1:0] opcode;
    logic [3:0] opcode2;

    logic       fetch_req, reg_write, imm_sel, alu_src, pc_inc, pc_load, busy, illegal;
    logic [1:0] alu_con;
    logic [15:0] retired;
    logic       fetch_req2, reg_write2, imm_sel2, alu_src2, pc_inc2, pc_load2, busy2, illegal2;
    logic [1:0] alu_con2;
    logic [1:0] retired2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_fetch_ack(fetch_ack),
        .i_opcode(opcode), .i_stall(stall), .i_trap_clr(trap_clr),
        .o_fetch_req(fetch_req), .o_reg_write(reg_write), .o_alu_con(alu_con),
        .o_imm_sel(imm_sel), .o_alu_src(alu_src), .o_pc_inc(pc_inc),
        .o_pc_load(pc_load), .o_busy(busy), .o_illegal(illegal), .o_retired(retired)
    );

    multicycle_control_fsm #(.OPCODE_W(4), .CNT_W(2), .ALU_CON_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_fetch_ack(fetch_ack),
        .i_opcode(opcode2), .i_stall(stall), .i_trap_clr(trap_clr),
        .o_fetch_req(fetch_req2), .o_reg_write(reg_write2), .o_alu_con(alu_con2),
        .o_imm_sel(imm_sel2), .o_alu_src(alu_src2), .o_pc_inc(pc_inc2),
        .o_pc_load(pc_load2), .o_busy(busy2), .o_illegal(illegal2), .o_retired(retired2)
    );

    // {fetch_req, reg_write, alu_con[1:0], imm_sel, alu_src, pc_inc, pc_load, busy, illegal}
    localparam logic [9:0] O_IDLE = 10'b0_0_00_0_0_0_0_0_0;
    localparam logic [9:0] O_FET  = 10'b1_0_00_0_0_0_0_1_0;
    localparam logic [9:0] O_DEC  = 10'b0_0_00_0_0_0_0_1_0;
    localparam logic [9:0] O_LIX  = 10'b0_0_00_1_1_0_0_1_0;
    localparam logic [9:0] O_LIW  = 10'b0_1_00_1_1_1_0_1_0;
    localparam logic [9:0] O_ADX  = 10'b0_0_01_0_0_0_0_1_0;
    localparam logic [9:0] O_ADW  = 10'b0_1_01_0_0_1_0_1_0;
    localparam logic [9:0] O_JMP  = 10'b0_0_11_0_0_0_1_1_0;
    localparam logic [9:0] O_JMS  = 10'b0_0_11_0_0_0_0_1_0;
    localparam logic [9:0] O_TRP  = 10'b0_0_00_0_0_0_0_0_1;

    typedef struct {
        logic       st, ack;
        logic [1:0] op;
        logic       stl, tc;
        logic [9:0] eo;
        int         ret;
    } vec_t;

    vec_t vt[36];

    function automatic vec_t v(logic st, logic ack, logic [1:0] op, logic stl, logic tc,
                               logic [9:0] eo, int ret);
        vec_t r;
        r.st = st; r.ack = ack; r.op = op; r.stl = stl; r.tc = tc; r.eo = eo; r.ret = ret;
        return r;
    endfunction

    function automatic logic [9:0] outs1();
        return {fetch_req, reg_write, alu_con, imm_sel, alu_src, pc_inc, pc_load, busy, illegal};
    endfunction

    function automatic logic [9:0] outs2();
        return {fetch_req2, reg_write2, alu_con2, imm_sel2, alu_src2, pc_inc2, pc_load2, busy2, illegal2};
    endfunction

    task automatic chk(input string nm, input logic [9:0] a, input logic [9:0] e,
                       input int ar, input int er);
        total++;
        if (a !== e || ar != er) begin
            bad++;
            $display("FAIL %s: got outs=%b retired=%0d, want outs=%b retired=%0d", nm, a, ar, e, er);
        end
    endtask

    task automatic drive(input logic st, input logic ack, input logic [1:0] op,
                         input logic stl, input logic tc);
        start = st; fetch_ack = ack; opcode = op; stall = stl; trap_clr = tc;
        // Wide instance sees opcode 7 wherever the narrow one sees illegal code 2.
        opcode2 = (op == 2'd2) ? 4'd7 : {2'b00, op};
    endtask

    initial begin
        // li, add, jump, delayed ack with opcode churn, stalled WB, trap, stalled jump
        vt[0]  = v(1,0,0,0,0, O_IDLE, 0);
        vt[1]  = v(0,1,0,0,0, O_FET,  0);
        vt[2]  = v(0,1,1,0,0, O_DEC,  0);
        vt[3]  = v(0,1,1,0,0, O_LIX,  0);
        vt[4]  = v(0,1,1,0,0, O_LIW,  0);
        vt[5]  = v(0,1,1,0,0, O_FET,  1);
        vt[6]  = v(0,1,3,0,0, O_DEC,  1);
        vt[7]  = v(0,1,3,0,0, O_ADX,  1);
        vt[8]  = v(0,1,3,0,0, O_ADW,  1);
        vt[9]  = v(0,1,3,0,0, O_FET,  2);
        vt[10] = v(0,1,0,0,0, O_DEC,  2);
        vt[11] = v(0,1,0,0,0, O_JMP,  2);
        vt[12] = v(0,0,3,0,0, O_FET,  3);
        vt[13] = v(0,0,2,0,0, O_FET,  3);
        vt[14] = v(0,0,0,0,0, O_FET,  3);
        vt[15] = v(0,0,3,0,0, O_FET,  3);
        vt[16] = v(0,0,2,0,0, O_FET,  3);
        vt[17] = v(0,1,1,0,0, O_FET,  3);
        vt[18] = v(0,1,3,0,0, O_DEC,  3);
        vt[19] = v(0,1,3,0,0, O_ADX,  3);
        vt[20] = v(0,0,0,1,0, O_ADX,  3);
        vt[21] = v(0,0,0,1,0, O_ADX,  3);
        vt[22] = v(0,0,0,1,0, O_ADX,  3);
        vt[23] = v(0,0,0,0,0, O_ADW,  3);
        vt[24] = v(0,1,2,0,0, O_FET,  4);
        vt[25] = v(0,0,0,0,1, O_DEC,  4);
        vt[26] = v(1,0,0,0,0, O_TRP,  4);
        vt[27] = v(0,0,0,0,1, O_TRP,  4);
        vt[28] = v(0,0,0,0,0, O_IDLE, 4);
        vt[29] = v(1,0,0,0,0, O_IDLE, 4);
        vt[30] = v(0,1,3,1,0, O_FET,  4);
        vt[31] = v(0,0,0,1,0, O_DEC,  4);
        vt[32] = v(0,0,0,0,0, O_DEC,  4);
        vt[33] = v(0,0,0,1,0, O_JMS,  4);
        vt[34] = v(0,0,0,0,0, O_JMP,  4);
        vt[35] = v(1,0,0,0,1, O_FET,  5);

        rst_n = 1'b0;
        drive(0,0,0,0,0);
        #3;
        chk("reset", outs1(), O_IDLE, int'(retired), 0);
        chk("reset_w", outs2(), O_IDLE, int'(retired2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].st, vt[i].ack, vt[i].op, vt[i].stl, vt[i].tc);
            #1;
            chk($sformatf("vec%0d", i), outs1(), vt[i].eo, int'(retired), vt[i].ret);
            chk($sformatf("vec%0d_w", i), outs2(), vt[i].eo, int'(retired2), vt[i].ret % 4);
            @(negedge clk);
        end

        // add fetched, then reset asserted asynchronously during its EXEC
        drive(0,1,1,0,0);
        @(negedge clk);
        drive(0,0,0,0,0);
        @(negedge clk);
        #1;
        chk("rst_pre_exec", outs1(), O_ADX, int'(retired), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", outs1(), O_IDLE, int'(retired), 0);
        chk("rst_async_w", outs2(), O_IDLE, int'(retired2), 0);
        @(posedge clk);
        #1;
        chk("rst_hold", outs1(), O_IDLE, int'(retired), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_idle", outs1(), O_IDLE, int'(retired), 0);
        @(posedge clk);
        #1;
        chk("rst_no_wb", outs1(), O_IDLE, int'(retired), 0);
        @(negedge clk);
        drive(1,0,0,0,0);
        @(negedge clk);
        drive(0,0,0,0,0);
        #1;
        chk("restart_fetch", outs1(), O_FET, int'(retired), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle control unit for the small-ISA core; the next generation of the single-cycle opcode decoder.
- Sequences each instruction through FETCH, DECODE, EXEC and WB, with a request/acknowledge handshake to instruction memory.
- Drives datapath controls for one state only, supports stall and illegal-opcode trap, and counts retired instructions.
- Sits between the instruction-memory port and the register file/ALU/PC datapath.

Parameters:
- OPCODE_W, 2, opcode width (min 2). Codes 0 = li, 1 = add, 3 = jump; all other codes are illegal.
- CNT_W, 16, width of the retired-instruction counter.
- ALU_CON_W, 2, width of the ALU control field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  leave IDLE and begin fetching.
- fetch_ack  in  1  imem has a valid opcode this cycle.
- opcode  in  OPCODE_W  instruction opcode, sampled only when fetch_req && fetch_ack.
- stall  in  1  freeze FSM in DECODE/EXEC/WB.
- trap_clr  in  1  leave TRAP.
- fetch_req  out  1  instruction-fetch request.
- reg_write  out  1  register-file write enable.
- alu_con  out  ALU_CON_W  ALU operation: li = 0, add = 1, jump = 3.
- imm_sel  out  1  select immediate.
- alu_src  out  1  ALU B operand from immediate.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  PC <= jump target.
- busy  out  1  FSM not in IDLE or TRAP.
- illegal  out  1  high while in TRAP.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; latched opcode = 0; retired = 0.
  - All control outputs are 0 immediately, without waiting for a clock edge.
- All outputs are registered or decoded from state plus the latched opcode only; no output depends combinationally on opcode.
- IDLE: all outputs 0. start = 1 moves to FETCH on the next edge.
- FETCH:
  - fetch_req = 1; wait while fetch_ack = 0.
  - On fetch_ack = 1: latch opcode and go to DECODE.
  - stall is ignored in FETCH.
- DECODE:
  - Opcode illegal: go to TRAP.
  - Otherwise go to EXEC. Control outputs stay 0.
- EXEC, decoded from the latched opcode:
  - li: alu_con = 0, imm_sel = 1, alu_src = 1.
  - add: alu_con = 1, imm_sel = 0, alu_src = 0.
  - jump: alu_con = 3, pc_load = 1 for exactly one cycle. Then go to FETCH and retired += 1; no WB for jump.
  - li/add: go to WB.
- WB:
  - reg_write = 1 and pc_inc = 1 for one cycle.
  - alu_con, imm_sel and alu_src keep their EXEC values.
  - Then go to FETCH and retired += 1.
- stall = 1 in DECODE, EXEC or WB:
  - The state is held.
  - reg_write, pc_inc and pc_load are forced to 0 while stalled, so each pulse fires exactly once, in the first unstalled cycle of its state.
  - alu_con, imm_sel and alu_src stay held.
- TRAP:
  - illegal = 1, busy = 0, all other controls 0.
  - trap_clr = 1 returns to IDLE.
  - retired is not incremented for an illegal instruction.
- Latency with fetch_ack already high and no stall:
  - li/add: 4 cycles, FETCH to FETCH.
  - jump: 3 cycles.
- retired wraps modulo 2^CNT_W.
- start is ignored outside IDLE; trap_clr is ignored outside TRAP.
- Reset asserted mid-instruction: abort immediately. No write or PC update may occur on or after the reset edge.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state enum (IDLE, FETCH, DECODE, EXEC, WB, TRAP);
  - opcode constants OP_LI = 0, OP_ADD = 1, OP_JMP = 3;
  - ALU_CON constants.
- One natural sub-module: ctrl_decode.
  - Combinational: latched opcode in; alu_con, imm_sel, alu_src, is_jump, is_illegal out.
  - Instanced once; the FSM uses it for EXEC/WB outputs and the DECODE branch.

Test Plan:
- li then add, fetch_ack always 1 → li EXEC shows imm_sel = 1, alu_src = 1, alu_con = 0. reg_write and pc_inc pulse once in cycle 4, retired = 1. add follows in cycles 5–8, retired = 2.
- jump (opcode 3) → pc_load = 1 for exactly one cycle in EXEC, reg_write never asserted, FETCH reached 3 cycles after fetch start, retired += 1.
- fetch_ack held low 5 cycles, then add → fetch_req high for 6 cycles, opcode sampled only on the ack cycle; changing opcode before the ack has no effect.
- stall = 1 for 3 cycles on entering WB of add → reg_write stays 0 for those 3 cycles, then pulses once. alu_con = 1 is held throughout.
- opcode 2 → TRAP after DECODE with illegal = 1, retired unchanged. trap_clr → IDLE. With OPCODE_W = 4, opcode 7 also traps.
- rst_n low in the EXEC of add → all outputs 0 asynchronously and no reg_write pulse. After release, state = IDLE and retired = 0. Also with CNT_W = 2, 5 retirements → retired = 1 (wrap).
